muldiv_sequencer: RTL and testbench

Multi-cycle controller for the MUL (operation 4'b0010) and DIV (operation 4'b0011) ALU operations.
- Sits in the execute stage beside the single-cycle ALU and takes the same 4-bit operation code.
- Runs an iterative unsigned shift-add multiply or a restoring divide over WIDTH cycles.
- Stalls the pipeline while busy, then presents a one-cycle result.

---
 rtl/muldiv_sequencer_pkg.sv | 19 +
 rtl/muldiv_iter_unit.sv | 71 +++++++
 rtl/muldiv_sequencer.sv | 135 +++++++++++++
 tb/tb_muldiv_sequencer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_sequencer_pkg.sv
// rtl/muldiv_sequencer_pkg.sv - shared opcodes, state encoding and decode helper for the MUL/DIV sequencer
package muldiv_sequencer_pkg;

    // ALU operation encodings that the sequencer acts on
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0011;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MUL_RUN = 2'd1,
        ST_DIV_RUN = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_iter_unit.sv
// rtl/muldiv_iter_unit.sv - datapath performing one shift-add multiply or restoring-divide step per enable
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_load            latch operands and select operation
//   i_load_div        1 = divide, 0 = multiply (sampled with i_load)
//   i_operand_a/b     multiplicand/multiplier or dividend/divisor
//   i_step            advance one iteration
//   o_next_lo/hi      value the accumulator takes on the next step
//                     (product lo/hi, or quotient/remainder)
import muldiv_sequencer_pkg::*;

module muldiv_iter_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_load_div,
    input  logic [WIDTH-1:0] i_operand_a,
    input  logic [WIDTH-1:0] i_operand_b,
    input  logic             i_step,
    output logic [WIDTH-1:0] o_next_lo,
    output logic [WIDTH-1:0] o_next_hi
);

    // Multiply: r_acc = {partial product, remaining multiplier bits}.
    // Divide:   r_acc = {partial remainder, dividend bits / quotient bits}.
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_op;      // multiplicand or divisor
    logic               r_is_div;

    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH:0]     w_div_diff;
    logic               w_div_ge;
    logic [2*WIDTH-1:0] w_next_acc;

    always_comb begin
        // Carry out of the add is kept and shifted back into the top bit
        w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_op} : '0);
        // Remainder shifted left with the next dividend bit brought in
        w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
        w_div_ge    = (w_div_shift >= {1'b0, r_op});
        w_div_diff  = w_div_shift - {1'b0, r_op};
        if (r_is_div) begin
            w_next_acc = {(w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0]),
                          r_acc[WIDTH-2:0], w_div_ge};
        end else begin
            w_next_acc = {w_mul_sum, r_acc[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_op     <= '0;
            r_is_div <= 1'b0;
        end else if (i_load) begin
            r_is_div <= i_load_div;
            r_acc    <= i_load_div ? {{WIDTH{1'b0}}, i_operand_a} : {{WIDTH{1'b0}}, i_operand_b};
            r_op     <= i_load_div ? i_operand_b : i_operand_a;
        end else if (i_step) begin
            r_acc <= w_next_acc;
        end
    end

    assign o_next_lo = w_next_acc[WIDTH-1:0];
    assign o_next_hi = w_next_acc[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - multi-cycle MUL/DIV controller with pipeline stall, flush and divide-by-zero
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   op_valid, operation      execute-stage instruction and ALU opcode
//   operand_a, operand_b     multiplicand/dividend, multiplier/divisor
//   flush                    abort any in-flight operation
//   stall                    hold upstream pipeline (combinational)
//   busy                     iterating (MUL_RUN or DIV_RUN)
//   result_valid             one-cycle result pulse
//   result_lo, result_hi     product lo/hi or quotient/remainder
//   div_by_zero              last DIV had a zero divisor
import muldiv_sequencer_pkg::*;

module muldiv_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic [3:0]       operation,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             result_valid,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           r_state;
    logic [CW-1:0]    r_count;
    logic             r_busy;
    logic             r_result_valid;
    logic [WIDTH-1:0] r_result_lo;
    logic [WIDTH-1:0] r_result_hi;
    logic             r_div_by_zero;

    logic             w_accept;
    logic             w_is_div;
    logic             w_div_zero;
    logic             w_running;
    logic             w_step;
    logic [WIDTH-1:0] w_next_lo;
    logic [WIDTH-1:0] w_next_hi;

    assign w_is_div   = (operation == OP_DIV);
    assign w_div_zero = w_is_div && (operand_b == '0);
    assign w_accept   = (r_state == ST_IDLE) && op_valid && is_muldiv(operation) && !flush;
    assign w_running  = (r_state == ST_MUL_RUN) || (r_state == ST_DIV_RUN);
    assign w_step     = w_running && !flush;

    // Stall is raised in the accept cycle itself so the instruction stays put
    assign stall = w_accept || w_running;

    muldiv_iter_unit #(.WIDTH(WIDTH)) u_iter (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_accept),
        .i_load_div  (w_is_div),
        .i_operand_a (operand_a),
        .i_operand_b (operand_b),
        .i_step      (w_step),
        .o_next_lo   (w_next_lo),
        .o_next_hi   (w_next_hi)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_count        <= '0;
            r_busy         <= 1'b0;
            r_result_valid <= 1'b0;
            r_result_lo    <= '0;
            r_result_hi    <= '0;
            r_div_by_zero  <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_count       <= CW'(WIDTH);
                        r_div_by_zero <= 1'b0;
                        if (w_div_zero) begin
                            // Zero divisor skips iteration entirely
                            r_state        <= ST_DONE;
                            r_result_valid <= 1'b1;
                            r_result_lo    <= '1;
                            r_result_hi    <= operand_a;
                            r_div_by_zero  <= 1'b1;
                        end else begin
                            r_state <= w_is_div ? ST_DIV_RUN : ST_MUL_RUN;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                ST_MUL_RUN, ST_DIV_RUN: begin
                    if (flush) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_count <= r_count - 1'b1;
                        // Final step: capture the value the datapath is committing now
                        if (r_count == CW'(1)) begin
                            r_state        <= ST_DONE;
                            r_busy         <= 1'b0;
                            r_result_valid <= 1'b1;
                            r_result_lo    <= w_next_lo;
                            r_result_hi    <= w_next_hi;
                        end
                    end
                end
                ST_DONE: begin
                    // op_valid here is the same instruction still held upstream
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy         = r_busy;
    assign result_valid = r_result_valid;
    assign result_lo    = r_result_lo;
    assign result_hi    = r_result_hi;
    assign div_by_zero  = r_div_by_zero;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - scoreboard bench for muldiv_sequencer with arithmetic reference model
module tb_muldiv_sequencer;

    localparam int W = 16;
    localparam logic [3:0] T_MUL = 4'b0010;
    localparam logic [3:0] T_DIV = 4'b0011;

    logic         clk = 1'b0;
    logic         rst;
    logic         op_valid;
    logic [3:0]   operation;
    logic [W-1:0] operand_a;
    logic [W-1:0] operand_b;
    logic         flush;
    logic         stall;
    logic         busy;
    logic         result_valid;
    logic [W-1:0] result_lo;
    logic [W-1:0] result_hi;
    logic         div_by_zero;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .op_valid     (op_valid),
        .operation    (operation),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .flush        (flush),
        .stall        (stall),
        .busy         (busy),
        .result_valid (result_valid),
        .result_lo    (result_lo),
        .result_hi    (result_hi),
        .div_by_zero  (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         dbz;
        int           t0;
        int           lat;
    } exp_t;

    exp_t         sb[$];
    exp_t         mon_e;
    int           n_checks = 0;
    int           n_fail   = 0;
    int           cyc      = 0;
    logic [W-1:0] m_lo = '0;
    logic [W-1:0] m_hi = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on the operands
    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input int t0);
        exp_t e;
        logic [2*W-1:0] p;
        e.t0 = t0;
        e.dbz = 1'b0;
        e.lat = W + 1;
        if (op == T_MUL) begin
            p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            e.lo = p[W-1:0];
            e.hi = p[2*W-1:W];
        end else if (b == 0) begin
            e.lo = '1;
            e.hi = a;
            e.dbz = 1'b1;
            e.lat = 1;
        end else begin
            e.lo = a / b;
            e.hi = a % b;
        end
        return e;
    endfunction

    // Monitor: every result pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && result_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result_valid: got 1 expected 0 (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("result_lo", result_lo, mon_e.lo);
                chk("result_hi", result_hi, mon_e.hi);
                chk("div_by_zero", div_by_zero, mon_e.dbz);
                chk("latency", cyc - mon_e.t0, mon_e.lat);
            end
        end
    end

    // Called at a negedge; drives the instruction, holds it through DONE like a pipeline would
    task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   n;
        int   sc;
        operation = op;
        operand_a = a;
        operand_b = b;
        op_valid  = 1'b1;
        e = model(op, a, b, cyc);
        sb.push_back(e);
        #1;
        chk("stall_at_accept", stall, 1'b1);
        @(negedge clk);
        n  = 0;
        sc = 0;
        while (!result_valid && n < 100) begin
            if (stall && busy) sc++;
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            chk("result_timeout", 1'b0, 1'b1);
            void'(sb.pop_back());
        end else begin
            chk("stall_cycles", sc, e.dbz ? 0 : W);
            chk("stall_in_done", stall, 1'b0);
            m_lo = e.lo;
            m_hi = e.hi;
        end
        @(negedge clk);
        op_valid = 1'b0;
        chk("no_restart_busy", busy, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        op_valid = 1'b0;
        operation = '0;
        operand_a = '0;
        operand_b = '0;
        flush = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_result_valid", result_valid, 1'b0);
        chk("rst_lo", result_lo, 0);
        chk("rst_hi", result_hi, 0);
        chk("rst_dbz", div_by_zero, 1'b0);
        chk("rst_stall", stall, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases
        do_op(T_MUL, 16'd300, 16'd200);
        do_op(T_MUL, 16'hFFFF, 16'hFFFF);
        do_op(T_DIV, 16'd1000, 16'd7);
        do_op(T_DIV, 16'd1234, 16'd0);
        do_op(T_DIV, 16'd5, 16'd9);
        do_op(T_DIV, 16'hFFFF, 16'd1);

        // Non-MUL/DIV opcode is ignored
        operation = 4'b0000;
        op_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("addop_stall", stall, 1'b0);
            @(negedge clk);
            chk("addop_busy", busy, 1'b0);
        end
        op_valid = 1'b0;

        // Flush in IDLE suppresses accept
        operation = T_MUL;
        operand_a = 16'd3;
        operand_b = 16'd4;
        op_valid  = 1'b1;
        flush     = 1'b1;
        #1;
        chk("idle_flush_stall", stall, 1'b0);
        @(negedge clk);
        chk("idle_flush_busy", busy, 1'b0);
        flush    = 1'b0;
        op_valid = 1'b0;
        @(negedge clk);

        // Flush on cycle 5 of a MUL, then a DIV right after
        operation = T_MUL;
        operand_a = 16'd1111;
        operand_b = 16'd2222;
        op_valid  = 1'b1;
        sb.push_back(model(T_MUL, 16'd1111, 16'd2222, cyc));
        repeat (5) @(negedge clk);
        chk("busy_before_flush", busy, 1'b1);
        flush = 1'b1;
        @(negedge clk);
        flush    = 1'b0;
        op_valid = 1'b0;
        void'(sb.pop_back());
        chk("flush_busy", busy, 1'b0);
        chk("flush_keep_lo", result_lo, m_lo);
        chk("flush_keep_hi", result_hi, m_hi);
        do_op(T_DIV, 16'd50000, 16'd123);

        // Reset in the middle of a DIV
        operation = T_DIV;
        operand_a = 16'd777;
        operand_b = 16'd5;
        op_valid  = 1'b1;
        sb.push_back(model(T_DIV, 16'd777, 16'd5, cyc));
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        void'(sb.pop_back());
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_valid", result_valid, 1'b0);
        chk("midrst_lo", result_lo, 0);
        chk("midrst_hi", result_hi, 0);
        chk("midrst_dbz", div_by_zero, 1'b0);
        rst      = 1'b0;
        op_valid = 1'b0;
        m_lo = '0;
        m_hi = '0;
        @(negedge clk);
        chk("post_rst_busy", busy, 1'b0);

        // Back-to-back MULs with a single idle cycle between them
        do_op(T_MUL, 16'd12345, 16'd54321);
        do_op(T_MUL, 16'd65535, 16'd2);

        // Random traffic
        for (int i = 0; i < 24; i++) begin
            logic [3:0]   op;
            logic [W-1:0] a;
            logic [W-1:0] b;
            op = ($urandom_range(0, 1) == 0) ? T_MUL : T_DIV;
            a  = W'($urandom);
            b  = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
            do_op(op, a, b);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
